wasm_globals_arbiter: RTL
=========================

Name: wasm_globals_arbiter

Overview:
Two-requester arbiter and sequencer in front of the wasm_globals storage block. It shares the single read/write port between the execution core (global.get/global.set) and the host/debug port. It owns the request/grant handshake and the write-response wait state, and it returns per-requester read data and error status. It sits between the core datapath, the host bridge and wasm_globals.

Parameters:
MAX_STARVE, 4, consecutive cycles a pending host request may lose to the core before it is forced a grant (1..15).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
core_req  in  1  core request; held stable until core_gnt
core_we  in  1  1=write, 0=read
core_idx  in  8  global index
core_wdata  in  stack_entry_t  write data
core_gnt  out  1  request accepted this cycle (comb)
core_rsp_valid  out  1  one-cycle response pulse
core_rsp_data  out  stack_entry_t  read data (zero for writes/errors)
core_rsp_err  out  1  read out of range, or write to immutable/out-of-range global
host_req, host_we, host_idx, host_wdata, host_gnt, host_rsp_valid, host_rsp_data, host_rsp_err  same as core_*, host side
gl_rd_en  out  1  to wasm_globals
gl_rd_idx  out  8
gl_rd_data  in  stack_entry_t  combinational from storage
gl_rd_valid  in  1  combinational from storage
gl_wr_en  out  1
gl_wr_idx  out  8
gl_wr_data  out  stack_entry_t
gl_wr_valid  in  1  registered in storage, arrives cycle after gl_wr_en
gl_wr_error  in  1  registered in storage
busy  out  1  FSM not IDLE
stat_core_grants  out  16  grant counter (optional feature)
stat_host_grants  out  16
stat_errors  out  16

Behaviour:
- Reset (sync, rst_n low at posedge): state=IDLE, starve_cnt=0. All gnt, rsp_valid and rsp_err outputs are 0; rsp_data=0; stat counters=0. Any pending write response is dropped and no rsp_valid is issued for it.
- FSM states:
  - IDLE: accept at most one request per cycle.
  - WR_WAIT: one cycle; sample gl_wr_valid/gl_wr_error; return to IDLE. No grants are issued in WR_WAIT.
- Arbitration in IDLE:
  - Core wins by default.
  - Host wins if only host_req is asserted, or if starve_cnt==MAX_STARVE.
  - starve_cnt increments each IDLE cycle in which host_req=1 and the host loses. It clears when the host is granted or when host_req=0. It saturates at MAX_STARVE.
  - WR_WAIT cycles do not count toward starvation.
- Grant cycle N:
  - gnt=1 to the winner. gl_rd_en or gl_wr_en is driven with the winner's idx/wdata combinationally; all other gl_* outputs are 0.
  - Read: gl_rd_data/gl_rd_valid are registered at the edge ending N. rsp_valid=1 in N+1; rsp_err=!gl_rd_valid; rsp_data=gl_rd_data if valid, else 0. Read latency is 1.
  - Write: go to WR_WAIT in N+1 and capture gl_wr_valid/gl_wr_error. rsp_valid=1 in N+2 with rsp_err=gl_wr_error|!gl_wr_valid and rsp_data=0. Write latency is 2.
- Throughput: reads 1/cycle; writes 1 per 2 cycles.
- Ordering:
  - A read granted in the cycle after WR_WAIT observes the new value.
  - A read cannot overlap a write.
- Response mux: the response goes only to the requester recorded at grant time (a 1-bit owner register). The other requester's rsp_valid stays 0.
- Simultaneous events: the two rsp_valid outputs are never both high. A read response in N+1 may coincide with a new grant in N+1.
- A requester deasserting req without a grant is legal and has no effect.
- Changing idx/we/wdata while req=1 and gnt=0 is legal; values are sampled only in the grant cycle.

Optional Feature:
WASM_GLOBALS_ARB_STATS_EN
- Defined: stat_core_grants and stat_host_grants increment on each grant. stat_errors increments on each rsp_valid with rsp_err=1. All counters are 16-bit, saturate at 0xFFFF and reset to 0.
- Undefined: stat_* are tied to 0 and no counter flops exist.

Decomposition:
- Shared package wasm_pkg:
  - stack_entry_t (existing)
  - new enum arb_state_t {ARB_IDLE, ARB_WR_WAIT}
  - new enum arb_owner_t {OWN_CORE, OWN_HOST}
- Sub-module: wasm_arb_starve_cnt (saturating starvation counter plus force-grant compare), parameterised by MAX_STARVE. Everything else stays in one module.

Test Plan:
1. Core read idx 3 (global 3 = i32 0x0000_002A, count=8) -> core_gnt in N, core_rsp_valid in N+1, data 0x2A, err=0.
2. Host write idx 2 (mutable) value 0x55 -> host_gnt in N, busy in N+1, host_rsp_valid in N+2 with err=0. Core read idx 2 granted in N+2 -> data 0x55.
3. Core write idx 1 (immutable) -> core_rsp_err=1 at N+2, value unchanged. Core read idx 9 (≥count) -> err=1, data 0.
4. core_req and host_req held high continuously with MAX_STARVE=4, reads only -> grant pattern core,core,core,core,host repeats. The host is never starved beyond 5 cycles.
5. Core write granted, rst_n low during WR_WAIT -> no rsp_valid, busy=0 next cycle, all outputs at reset values.
6. With WASM_GLOBALS_ARB_STATS_EN: 3 core reads, 2 host writes (one immutable) -> stat_core_grants=3, stat_host_grants=2, stat_errors=1. Without the macro, all stats read 0.

Source files
------------

// File: rtl/wasm_pkg.sv
// Shared types for the wasm execution block: stack entries, arbiter FSM state,
// arbiter response owner and a saturating increment helper for statistics.
package wasm_pkg;

    typedef enum logic [1:0] {
        VT_I32 = 2'd0,
        VT_I64 = 2'd1,
        VT_F32 = 2'd2,
        VT_F64 = 2'd3
    } val_type_t;

    typedef struct packed {
        val_type_t   vtype;
        logic [63:0] value;
    } stack_entry_t;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_WR_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } arb_owner_t;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wasm_arb_starve_cnt.sv
// Host starvation counter for wasm_globals_arbiter. Counts IDLE cycles in which
// the host is requesting but loses to the core, saturating at MAX_STARVE, and
// raises o_force once the limit is reached so the host takes the next grant.
module wasm_arb_starve_cnt #(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_idle,
    input  logic i_host_req,
    input  logic i_host_gnt,
    output logic o_force
);

    localparam logic [3:0] LP_MAX = 4'(MAX_STARVE);

    logic [3:0] r_cnt;

    // Clear when the host is served or stops asking; count lost IDLE cycles only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (!i_host_req || i_host_gnt) begin
            r_cnt <= 4'd0;
        end else if (i_idle && (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_force = (r_cnt == LP_MAX);

endmodule

// File: rtl/wasm_globals_arbiter.sv
// Two-requester arbiter/sequencer in front of wasm_globals. Shares the single
// storage port between the core and the host port. Core wins by default; the
// host wins when alone or when it has lost MAX_STARVE consecutive IDLE cycles.
// Reads respond one cycle after grant; writes pass through WR_WAIT and respond
// two cycles after grant. Optional statistics: WASM_GLOBALS_ARB_STATS_EN.
//
// Handshake: a requester holds req (with we/idx/wdata) until it sees gnt high
// in a cycle; the request is consumed at the clock edge ending that cycle and
// exactly one rsp_valid pulse follows on that requester's side only.
module wasm_globals_arbiter
    import wasm_pkg::*;
#(
    parameter int MAX_STARVE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         core_req,
    input  logic         core_we,
    input  logic [7:0]   core_idx,
    input  stack_entry_t core_wdata,
    output logic         core_gnt,
    output logic         core_rsp_valid,
    output stack_entry_t core_rsp_data,
    output logic         core_rsp_err,
    input  logic         host_req,
    input  logic         host_we,
    input  logic [7:0]   host_idx,
    input  stack_entry_t host_wdata,
    output logic         host_gnt,
    output logic         host_rsp_valid,
    output stack_entry_t host_rsp_data,
    output logic         host_rsp_err,
    output logic         gl_rd_en,
    output logic [7:0]   gl_rd_idx,
    input  stack_entry_t gl_rd_data,
    input  logic         gl_rd_valid,
    output logic         gl_wr_en,
    output logic [7:0]   gl_wr_idx,
    output stack_entry_t gl_wr_data,
    input  logic         gl_wr_valid,
    input  logic         gl_wr_error,
    output logic         busy,
    output logic [15:0]  stat_core_grants,
    output logic [15:0]  stat_host_grants,
    output logic [15:0]  stat_errors
);

    arb_state_t   r_state;
    arb_owner_t   r_owner;
    logic         r_rsp_valid;
    logic         r_rsp_err;
    stack_entry_t r_rsp_data;

    logic         w_idle;
    logic         w_force;
    logic         w_core_win;
    logic         w_host_win;
    logic         w_grant;
    logic         w_we;
    logic [7:0]   w_idx;
    stack_entry_t w_wdata;

    wasm_arb_starve_cnt #(
        .MAX_STARVE (MAX_STARVE)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_idle     (w_idle),
        .i_host_req (host_req),
        .i_host_gnt (w_host_win),
        .o_force    (w_force)
    );

    assign w_idle     = (r_state == ARB_IDLE);
    assign w_core_win = w_idle && core_req && !(host_req && w_force);
    assign w_host_win = w_idle && host_req && !w_core_win;
    assign w_grant    = w_core_win || w_host_win;

    assign w_we    = w_host_win ? host_we    : core_we;
    assign w_idx   = w_host_win ? host_idx   : core_idx;
    assign w_wdata = w_host_win ? host_wdata : core_wdata;

    assign core_gnt = w_core_win;
    assign host_gnt = w_host_win;
    assign busy     = !w_idle;

    assign gl_rd_en   = w_grant && !w_we;
    assign gl_rd_idx  = gl_rd_en ? w_idx : 8'd0;
    assign gl_wr_en   = w_grant && w_we;
    assign gl_wr_idx  = gl_wr_en ? w_idx : 8'd0;
    assign gl_wr_data = gl_wr_en ? w_wdata : '0;

    // Sequencer FSM: register read results at grant, hold one WR_WAIT cycle for writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_owner     <= OWN_CORE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_host_win ? OWN_HOST : OWN_CORE;
                        if (w_we) begin
                            r_state <= ARB_WR_WAIT;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= !gl_rd_valid;
                            r_rsp_data  <= gl_rd_valid ? gl_rd_data : '0;
                        end
                    end
                end
                ARB_WR_WAIT: begin
                    r_state     <= ARB_IDLE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= gl_wr_error || !gl_wr_valid;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign core_rsp_valid = r_rsp_valid && (r_owner == OWN_CORE);
    assign core_rsp_err   = core_rsp_valid && r_rsp_err;
    assign core_rsp_data  = core_rsp_valid ? r_rsp_data : '0;
    assign host_rsp_valid = r_rsp_valid && (r_owner == OWN_HOST);
    assign host_rsp_err   = host_rsp_valid && r_rsp_err;
    assign host_rsp_data  = host_rsp_valid ? r_rsp_data : '0;

`ifdef WASM_GLOBALS_ARB_STATS_EN
    logic [15:0] r_stat_core;
    logic [15:0] r_stat_host;
    logic [15:0] r_stat_err;

    // Saturating grant and error-response counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_core <= 16'd0;
            r_stat_host <= 16'd0;
            r_stat_err  <= 16'd0;
        end else begin
            if (w_core_win)               r_stat_core <= sat_inc(r_stat_core);
            if (w_host_win)               r_stat_host <= sat_inc(r_stat_host);
            if (r_rsp_valid && r_rsp_err) r_stat_err  <= sat_inc(r_stat_err);
        end
    end

    assign stat_core_grants = r_stat_core;
    assign stat_host_grants = r_stat_host;
    assign stat_errors      = r_stat_err;
`else
    assign stat_core_grants = 16'd0;
    assign stat_host_grants = 16'd0;
    assign stat_errors      = 16'd0;
`endif

endmodule
